seg_scan_driver: RTL and testbench

- Time-multiplexed scan driver for the 8-digit common-anode 7-segment display on the digital clock board.
- Latches a frame of 8 hex nibbles plus blank and decimal-point masks.
- Each scan slot selects one digit and presents its nibble on num_out, which feeds the hex-to-segment decoder. It also drives the active-low anode enables and the decimal point.
- Dead time between digits suppresses ghosting. Frame-boundary latching prevents tearing when the time counters update mid-scan.

---
 rtl/seg_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode 7-segment display.
// Optional digit blinking is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int DEAD_CYC   = 4,
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [3:0]              num_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SLOT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYC);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  if (DEAD_CYC < 2 || DEAD_CYC > SCAN_DIV - 2) begin : g_bad_dead_cyc
    $error("seg_scan_driver: DEAD_CYC must lie in 2..SCAN_DIV-2");
  end
  if (BLINK_HZ < 1 || CLK_HZ < 2 * BLINK_HZ) begin : g_bad_blink_hz
    $error("seg_scan_driver: BLINK_HZ must be in 1..CLK_HZ/2");
  end

  typedef enum logic {
    S_DEAD = 1'b0,
    S_ON   = 1'b1
  } slot_state_t;

  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_next;
  logic [DIG_W-1:0]  digit_idx;
  logic [DIG_W-1:0]  digit_next;
  logic              slot_wrap;
  logic              frame_start;
  logic              frame_end;

  slot_state_t       state_q;
  slot_state_t       state_next;

  logic [NUM_DIGITS-1:0][3:0] shadow_digits;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS-1:0]      shadow_blank;
  logic [NUM_DIGITS-1:0]      eff_blank;

  logic [NUM_DIGITS-1:0] an_p0;
  logic [3:0]            num_p0;
  logic                  dp_p0;
  logic                  done_p0;

  // Slot / digit position
  always_comb begin
    slot_wrap   = (slot_cnt == SLOT_LAST);
    frame_start = (slot_cnt == '0) && (digit_idx == '0);
    frame_end   = slot_wrap && (digit_idx == DIG_LAST);
    slot_next   = slot_wrap ? '0 : slot_cnt + 1'b1;
    digit_next  = digit_idx;
    if (slot_wrap) begin
      digit_next = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt  <= slot_next;
      digit_idx <= digit_next;
    end
  end

  // Slot FSM: register tracks the DEAD/ON decode of slot_cnt cycle for cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DEAD;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = (slot_next < DEAD_END) ? S_DEAD : S_ON;
  end

  // Frame latch: inputs are captured only at the top of a frame to avoid tearing
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '1;
    end else if (frame_start) begin
      shadow_digits <= digits_in;
      shadow_dp     <= dp_in;
      shadow_blank  <= blank_in;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] shadow_blink;

  // Free-running blink timebase, independent of scan position
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_blink <= '0;
    end else if (frame_start) begin
      shadow_blink <= blink_in;
    end
  end

  assign eff_blank = shadow_blank | ({NUM_DIGITS{blink_phase}} & shadow_blink);
`else
  logic unused_blink;

  assign unused_blink = ^blink_in;
  assign eff_blank    = shadow_blank;
`endif

  // Output decode; num/dp depend only on digit_idx and shadow, so they move in DEAD
  always_comb begin
    an_p0 = '1;
    if (state_q == S_ON && !eff_blank[digit_idx]) begin
      an_p0[digit_idx] = 1'b0;
    end
    num_p0  = shadow_digits[digit_idx];
    dp_p0   = ~shadow_dp[digit_idx];
    done_p0 = frame_end;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      an_out     <= '1;
      num_out    <= '0;
      dp_out     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_out     <= an_p0;
      num_out    <= num_p0;
      dp_out     <= dp_p0;
      frame_done <= done_p0;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a 10-cycle slot and 80-cycle frame.
module tb_seg_scan_driver;

  localparam int CLK_HZ     = 1000;
  localparam int SCAN_HZ    = 100;
  localparam int DEAD_CYC   = 2;
  localparam int NUM_DIGITS = 8;
  localparam int BLINK_HZ   = 5;
  localparam int FRAME      = 80;

  logic        clk;
  logic        rst;
  logic [31:0] digits_in;
  logic [7:0]  blank_in;
  logic [7:0]  dp_in;
  logic [7:0]  blink_in;
  logic [3:0]  num_out;
  logic        dp_out;
  logic [7:0]  an_out;
  logic        frame_done;

  int checks;
  int failures;

  seg_scan_driver #(
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .DEAD_CYC  (DEAD_CYC),
    .NUM_DIGITS(NUM_DIGITS),
    .BLINK_HZ  (BLINK_HZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .blank_in  (blank_in),
    .dp_in     (dp_in),
    .blink_in  (blink_in),
    .num_out   (num_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // After this returns, the next tick shows cycle 1 after reset release
  task automatic start_scan(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
    rst       = 1'b1;
    tick;
    tick;
    rst       = 1'b0;
  endtask

  // Expected anodes for outputs reflecting internal cycle k after release
  function automatic logic [7:0] exp_an(input int k, input logic [7:0] blk);
    int s;
    int d;
    s = k % 10;
    d = (k / 10) % 8;
    if (s >= DEAD_CYC && !blk[d]) return ~(8'h01 << d);
    return 8'hFF;
  endfunction

  task automatic test_reset;
    digits_in = 32'h89ABCDEF;
    blank_in  = 8'h00;
    dp_in     = 8'hFF;
    blink_in  = 8'h00;
    rst       = 1'b1;
    tick;
    tick;
    checks++;
    if (an_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_an got=%h want=ff", an_out);
    end
    checks++;
    if (num_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_num got=%h want=0", num_out);
    end
    checks++;
    if (dp_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_dp got=%b want=1", dp_out);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_done got=%b want=0", frame_done);
    end
  endtask

  task automatic test_scan;
    int k;
    int d;
    logic [3:0] en;
    logic       ef;
    start_scan(32'h76543210, 8'h00, 8'h00);
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick;
      k  = c - 1;
      d  = (k / 10) % 8;
      en = 4'(d);
      ef = (c % FRAME == 0);
      checks++;
      if (an_out !== exp_an(k, 8'h00)) begin
        failures++;
        $display("FAIL scan_an cycle=%0d got=%h want=%h", c, an_out, exp_an(k, 8'h00));
      end
      checks++;
      if (num_out !== en) begin
        failures++;
        $display("FAIL scan_num cycle=%0d got=%h want=%h", c, num_out, en);
      end
      checks++;
      if (dp_out !== 1'b1) begin
        failures++;
        $display("FAIL scan_dp cycle=%0d got=%b want=1", c, dp_out);
      end
      checks++;
      if (frame_done !== ef) begin
        failures++;
        $display("FAIL scan_frame_done cycle=%0d got=%b want=%b", c, frame_done, ef);
      end
    end
  endtask

  task automatic test_midframe_latch;
    int k;
    int d;
    logic [3:0] en;
    start_scan(32'h76543210, 8'h00, 8'h00);
    for (int c = 1; c <= 170; c++) begin
      tick;
      k = c - 1;
      d = (k / 10) % 8;
      if (k < FRAME) en = 4'(d);
      else if (k == FRAME) en = 4'h0;
      else en = 4'hF;
      checks++;
      if (num_out !== en) begin
        failures++;
        $display("FAIL midframe_num cycle=%0d got=%h want=%h", c, num_out, en);
      end
      checks++;
      if (an_out !== exp_an(k, 8'h00)) begin
        failures++;
        $display("FAIL midframe_an cycle=%0d got=%h want=%h", c, an_out, exp_an(k, 8'h00));
      end
      if (c == 35) digits_in = 32'hFFFFFFFF;
    end
  endtask

  task automatic test_blank_dp;
    int k;
    int d;
    logic ed;
    start_scan(32'h76543210, 8'h0C, 8'h01);
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick;
      k  = c - 1;
      d  = (k / 10) % 8;
      ed = (d == 0 && c != 1) ? 1'b0 : 1'b1;
      checks++;
      if (an_out !== exp_an(k, 8'h0C)) begin
        failures++;
        $display("FAIL blank_an cycle=%0d got=%h want=%h", c, an_out, exp_an(k, 8'h0C));
      end
      checks++;
      if (dp_out !== ed) begin
        failures++;
        $display("FAIL blank_dp cycle=%0d got=%b want=%b", c, dp_out, ed);
      end
      checks++;
      if (num_out !== 4'(d)) begin
        failures++;
        $display("FAIL blank_num cycle=%0d got=%h want=%h", c, num_out, 4'(d));
      end
    end
  endtask

  task automatic test_reset_mid_slot;
    int k;
    int d;
    logic [31:0] dv;
    logic [3:0]  en;
    logic        ed;
    logic        ef;
    start_scan(32'h76543210, 8'h00, 8'h00);
    for (int c = 1; c <= 55; c++) tick;
    checks++;
    if (an_out !== 8'hDF) begin
      failures++;
      $display("FAIL midrst_pre_an got=%h want=df", an_out);
    end
    dv        = 32'h89ABCDEF;
    digits_in = dv;
    dp_in     = 8'h02;
    rst       = 1'b1;
    tick;
    rst       = 1'b0;
    checks++;
    if (an_out !== 8'hFF) begin
      failures++;
      $display("FAIL midrst_an got=%h want=ff", an_out);
    end
    checks++;
    if (num_out !== 4'h0) begin
      failures++;
      $display("FAIL midrst_num got=%h want=0", num_out);
    end
    checks++;
    if (dp_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_dp got=%b want=1", dp_out);
    end
    for (int c = 1; c <= FRAME; c++) begin
      tick;
      k  = c - 1;
      d  = (k / 10) % 8;
      en = (c == 1) ? 4'h0 : dv[4*d +: 4];
      ed = (c != 1 && d == 1) ? 1'b0 : 1'b1;
      ef = (c == FRAME);
      checks++;
      if (an_out !== exp_an(k, 8'h00)) begin
        failures++;
        $display("FAIL restart_an cycle=%0d got=%h want=%h", c, an_out, exp_an(k, 8'h00));
      end
      checks++;
      if (num_out !== en) begin
        failures++;
        $display("FAIL restart_num cycle=%0d got=%h want=%h", c, num_out, en);
      end
      checks++;
      if (dp_out !== ed) begin
        failures++;
        $display("FAIL restart_dp cycle=%0d got=%b want=%b", c, dp_out, ed);
      end
      checks++;
      if (frame_done !== ef) begin
        failures++;
        $display("FAIL restart_frame_done cycle=%0d got=%b want=%b", c, frame_done, ef);
      end
    end
  endtask

  task automatic test_anode_invariant;
    int z;
    int idx;
    int last;
    int ones_run;
    int frames;
    last     = -1;
    ones_run = 0;
    frames   = 0;
    start_scan(32'h01234567, 8'h00, 8'hAA);
    for (int c = 1; c <= 10 * FRAME; c++) begin
      tick;
      z   = 0;
      idx = -1;
      for (int i = 0; i < 8; i++) begin
        if (an_out[i] == 1'b0) begin
          z++;
          idx = i;
        end
      end
      if (frame_done === 1'b1) frames++;
      checks++;
      if (z > 1) begin
        failures++;
        $display("FAIL onehot_an cycle=%0d got=%h want=at most one low bit", c, an_out);
      end
      if (z == 1) begin
        if (last >= 0 && idx != last) begin
          checks++;
          if (ones_run < 2) begin
            failures++;
            $display("FAIL dead_time cycle=%0d got=%0d want>=2 idle cycles", c, ones_run);
          end
        end
        last     = idx;
        ones_run = 0;
      end else if (an_out === 8'hFF) begin
        ones_run++;
      end
    end
    checks++;
    if (frames != 10) begin
      failures++;
      $display("FAIL frame_count got=%0d want=10", frames);
    end
  endtask

  task automatic test_blink;
    int k;
    logic [7:0] blk;
`ifdef SEG_SCAN_BLINK_EN
    blink_in = 8'h01;
    start_scan(32'h76543210, 8'h00, 8'h00);
    for (int c = 1; c <= 6 * FRAME; c++) begin
      tick;
      k   = c - 1;
      blk = ((k / 100) % 2 == 1) ? 8'h01 : 8'h00;
      checks++;
      if (an_out !== exp_an(k, blk)) begin
        failures++;
        $display("FAIL blink_an cycle=%0d got=%h want=%h", c, an_out, exp_an(k, blk));
      end
    end
`else
    blink_in = 8'hFF;
    start_scan(32'h76543210, 8'h00, 8'h00);
    blk = 8'h00;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick;
      k = c - 1;
      checks++;
      if (an_out !== exp_an(k, blk)) begin
        failures++;
        $display("FAIL blink_ignored_an cycle=%0d got=%h want=%h", c, an_out, exp_an(k, blk));
      end
    end
`endif
    blink_in = 8'h00;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    digits_in = '0;
    blank_in  = '0;
    dp_in     = '0;
    blink_in  = '0;
    test_reset;
    test_scan;
    test_midframe_latch;
    test_blank_dp;
    test_reset_mid_slot;
    test_anode_invariant;
    test_blink;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
